// File: rtl/lcd_fb_writer_if.sv
// Write-side bundle of the LCD framebuffer: pixel handshake, clear control and RAM write port.
// Handshake: a pixel transfers on a rising edge where px_valid and px_ready are both high;
// the requester holds px_x/px_y/px_index stable while px_valid is high and px_ready is low.
interface lcd_fb_writer_if #(
    parameter int ADDR_W = 19
);
    logic              px_valid;
    logic              px_ready;
    logic [9:0]        px_x;
    logic [9:0]        px_y;
    logic [3:0]        px_index;
    logic              clear_start;
    logic [3:0]        clear_index;
    logic              busy;
    logic              clear_done;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_data;
    logic              state_dbg;

    modport slave (
        input  px_valid, px_x, px_y, px_index, clear_start, clear_index,
        output px_ready, busy, clear_done, wr_en, wr_addr, wr_data, state_dbg
    );

    modport master (
        output px_valid, px_x, px_y, px_index, clear_start, clear_index,
        input  px_ready, busy, clear_done, wr_en, wr_addr, wr_data, state_dbg
    );
endinterface

// File: rtl/lcd_fb_writer.sv
// Framebuffer write port: single-pixel writes with coordinate-to-address conversion,
// plus a full-screen fill that sweeps every location once in ascending order.
module lcd_fb_writer #(
    parameter int H_RES    = 800,
    parameter int V_RES    = 480,
    parameter int FB_DEPTH = 384000,
    parameter int ADDR_W   = 19
) (
    input logic            clk,
    input logic            rst,
    lcd_fb_writer_if.slave fb
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [31:0]       H_LIM = H_RES;
    localparam logic [31:0]       V_LIM = V_RES;
    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(FB_DEPTH);

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [3:0]        idx_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [3:0]        wr_data_q;
    logic              busy_q;
    logic              done_q;

    logic              px_ready_c;
    logic              px_fire;
    logic              px_in_range;
    logic [ADDR_W-1:0] px_addr;

    // A clear request in the same cycle wins over a presented pixel.
    assign px_ready_c  = (state == ST_IDLE) & ~fb.clear_start;
    assign px_fire     = fb.px_valid & px_ready_c;
    assign px_in_range = (32'(fb.px_x) < H_LIM) & (32'(fb.px_y) < V_LIM);
    assign px_addr     = ADDR_W'(32'(fb.px_y) * H_LIM + 32'(fb.px_x));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == ST_IDLE) begin
                // Out-of-range pixels complete the handshake but never reach the RAM.
                wr_en_q <= px_fire & px_in_range;
                if (px_fire & px_in_range) begin
                    wr_addr_q <= px_addr;
                    wr_data_q <= fb.px_index;
                end
                if (fb.clear_start) begin
                    state <= ST_CLEAR;
                    idx_q <= fb.clear_index;
                    cnt   <= '0;
                end
            end else begin
                // cnt reaching DEPTH means the last location was written on the previous edge.
                if (cnt == DEPTH) begin
                    state   <= ST_IDLE;
                    busy_q  <= 1'b0;
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    busy_q    <= 1'b1;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= cnt;
                    wr_data_q <= idx_q;
                    cnt       <= cnt + 1'b1;
                end
            end
        end
    end

    assign fb.px_ready   = px_ready_c;
    assign fb.busy       = busy_q;
    assign fb.clear_done = done_q;
    assign fb.wr_en      = wr_en_q;
    assign fb.wr_addr    = wr_addr_q;
    assign fb.wr_data    = wr_data_q;
    assign fb.state_dbg  = state;
endmodule

// File: doc/lcd_fb_writer.md
# lcd_fb_writer

Write-side port of the LCD framebuffer. Accepts single-pixel writes (screen coordinate plus 4-bit palette index) over a valid/ready handshake and issues full-screen clear (fill) operations. It converts coordinates to linear framebuffer addresses and drives the RAM write port. The LCD scan-out path reads these locations back as palette indices.

## Interface
Parameters:
- `H_RES`, 800, visible width in pixels.
- `V_RES`, 480, visible height in lines.
- `FB_DEPTH`, 384000, framebuffer locations; one pixel per location; must equal `H_RES*V_RES`.
- `ADDR_W`, 19, RAM address width.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `px_valid`  in  1  pixel write request.
- `px_ready`  out  1  pixel write accepted when high together with `px_valid` at a rising edge.
- `px_x`  in  10  pixel column.
- `px_y`  in  10  pixel row.
- `px_index`  in  4  palette index to store.
- `clear_start`  in  1  single-cycle request to fill the whole framebuffer.
- `clear_index`  in  4  fill value; sampled with `clear_start`.
- `busy`  out  1  high while a clear is in progress.
- `clear_done`  out  1  one-cycle pulse after the last clear write.
- `wr_en`  out  1  RAM write enable.
- `wr_addr`  out  `ADDR_W`  RAM write address.
- `wr_data`  out  4  RAM write data.

## Operation
- FSM states are IDLE and CLEAR.
- Pixel accept:
  - `px_ready = (state == IDLE) & ~clear_start`, combinational.
  - A clear request therefore has priority over a pixel presented in the same cycle; that pixel is held off.
- Address: `y*H_RES + x`, computed at full width and truncated to `ADDR_W`. The maximum in-range value is 383999.
- Out-of-range pixel (`px_x >= H_RES` or `px_y >= V_RES`): it is accepted (handshake completes) and discarded. No `wr_en` is issued.
- IDLE to CLEAR:
  - Transition occurs when `clear_start` is high at a rising edge.
  - `clear_index` is latched and the clear counter is loaded with 0.
  - A pixel accepted in the previous cycle still completes its write before the first clear write.
- In CLEAR, one write is issued per cycle at addresses 0 through `FB_DEPTH-1` in ascending order, all carrying the latched index.
- After the write at `FB_DEPTH-1`, the FSM returns to IDLE and pulses `clear_done`.
- `clear_start` while in CLEAR is ignored; no restart and no queueing.
- There is no back-pressure from the RAM; a write is assumed to complete in the cycle it is issued.
- Reset asserted at any time aborts the operation:
  - State goes to IDLE.
  - Any partial clear is abandoned and the framebuffer content is undefined.
  - No `clear_done` is produced.

## Timing
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `clear_done=0`; state IDLE; counter 0.
- Once reset is released, `px_ready` reads 1 unless `clear_start` is high.
- All outputs except `px_ready` are registered.
- Pixel latency: a pixel accepted at edge N produces `wr_en=1` with its address and data during cycle N..N+1, registered at edge N. The write is thus visible to the RAM at edge N+1.
- Pixel throughput is 1 per cycle; back-to-back accepts produce back-to-back writes.
- Clear timing:
  - `clear_start` sampled at edge N.
  - `busy=1` and the first clear write (addr 0) are driven from edge N+1.
  - The write at addr k is driven from edge N+1+k; the last write (addr 383999) is driven from edge N+384000.
  - At edge N+384001: `busy=0`, `wr_en=0`, `clear_done=1` for exactly one cycle.
- `px_ready` is 0 from edge N+1 through edge N+384001. It is also 0 during cycle N itself, because of the combinational term on `clear_start`.
- `wr_en` stays low in any cycle with no accepted in-range pixel and no clear write.

## Test plan
- Reset, then a single pixel (x=5, y=2, idx=7) -> one cycle of `wr_en` with `wr_addr=1605`, `wr_data=7`, one cycle after the handshake.
- Corner pixels (0,0,idx 1) and (799,479,idx 14) back-to-back -> consecutive writes at addr 0 and 383999 with no bubble.
- Out-of-range pixels (800,0) and (0,480) -> both handshakes complete with `px_ready=1` and no `wr_en`.
- `clear_start` with idx 3 presented in the same cycle as a valid pixel:
  - The pixel is held (`px_ready=0`).
  - 384000 writes follow, addr 0 to 383999, data 3.
  - `busy` is high for exactly 384000 cycles, followed by a single `clear_done` pulse.
  - The held pixel is accepted the cycle after `clear_done` and written at its address.
- A second `clear_start` mid-clear -> ignored; write count stays 384000.
- Assert `rst` at clear write 1000 -> outputs return to reset values asynchronously, with no `clear_done`. Afterwards a pixel write works normally.
